// File: rtl/yuv422_to_444_if.sv
// AXI-stream style channel shared by the video chain stages.
// Latency: none (wiring only).
// Backpressure: t_ready from the sink, t_valid/payload from the source.
interface nasti_stream_channel #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1
);
    logic                    t_valid;
    logic                    t_ready;
    logic [DATA_WIDTH-1:0]   t_data;
    logic [DATA_WIDTH/8-1:0] t_strb;
    logic [DATA_WIDTH/8-1:0] t_keep;
    logic                    t_last;
    logic [DEST_WIDTH-1:0]   t_dest;
    logic [USER_WIDTH-1:0]   t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/yuv422_to_444.sv
// YUYV 4:2:2 -> padded 4:4:4 pixel pairs; each input beat becomes beat A (px 0,1) then beat B (px 2,3).
// Latency: beat A registered one edge after src handshake, beat B the cycle after beat A is accepted.
// Backpressure: full AXI-stream; src stalls while beat B is held. Optional macro CHROMA_INTERP_EN averages pixel 1 chroma.
module yuv422_to_444 #(
    parameter int DATA_WIDTH = 64,   // only 64 is supported
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    nasti_stream_channel.slave   src,
    nasti_stream_channel.master  dst
);

    localparam logic [0:0] ST_EMPTY  = 1'b0;  // nothing pending beyond the output register
    localparam logic [0:0] ST_SECOND = 1'b1;  // beat B parked in the hold register

    logic [0:0]            state_q,     state_d;
    logic                  dst_vld_q,   dst_vld_d;
    logic [DATA_WIDTH-1:0] dst_dat_q,   dst_dat_d;
    logic                  dst_last_q,  dst_last_d;
    logic [USER_WIDTH-1:0] dst_user_q,  dst_user_d;
    logic [DATA_WIDTH-1:0] hold_dat_q,  hold_dat_d;
    logic                  hold_last_q, hold_last_d;
    logic [USER_WIDTH-1:0] hold_user_q, hold_user_d;

    logic src_rdy;
    logic src_hs;
    logic dst_hs;

    // Unpacked input bytes: Y0 U0 Y1 V0 Y2 U1 Y3 V1 from byte 0 upwards.
    logic [7:0] y0, u0, y1, v0, y2, u1, y3, v1;
    logic [7:0] u_p1, v_p1;
    logic [63:0] beat_a, beat_b;

    function automatic logic [31:0] pix(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
        return {8'h00, y, u, v};
    endfunction

    assign {v1, y3, u1, y2, v0, y1, u0, y0} = src.t_data;

`ifdef CHROMA_INTERP_EN
    // Pixel 1 sits between the two chroma sites, so take their rounded mean.
    logic [8:0] u_sum, v_sum;
    logic       unused_sum_lsb;
    assign u_sum          = {1'b0, u0} + {1'b0, u1} + 9'd1;
    assign v_sum          = {1'b0, v0} + {1'b0, v1} + 9'd1;
    assign u_p1           = u_sum[8:1];
    assign v_p1           = v_sum[8:1];
    assign unused_sum_lsb = u_sum[0] ^ v_sum[0];
`else
    assign u_p1 = u0;
    assign v_p1 = v0;
`endif

    assign beat_a = {pix(y1, u_p1, v_p1), pix(y0, u0, v0)};
    assign beat_b = {pix(y3, u1, v1),     pix(y2, u1, v1)};

    // Input is accepted only with no beat B pending and the output register free or draining.
    assign src_rdy     = (state_q == ST_EMPTY) && (!dst_vld_q || dst.t_ready);
    assign src_hs      = src.t_valid && src_rdy;
    assign dst_hs      = dst_vld_q && dst.t_ready;
    assign src.t_ready = src_rdy;

    assign dst.t_valid = dst_vld_q;
    assign dst.t_data  = dst_dat_q;
    assign dst.t_last  = dst_last_q;
    assign dst.t_user  = dst_user_q;
    assign dst.t_keep  = '1;
    assign dst.t_strb  = '1;
    assign dst.t_dest  = {DEST_WIDTH{1'b0}};

    // Routing is unused here: the output destination is always 0.
    logic unused_src_dest;
    assign unused_src_dest = ^src.t_dest;

    // Next-state: load A and park B on input, then emit B before accepting more.
    always_comb begin
        state_d     = state_q;
        dst_vld_d   = dst_vld_q;
        dst_dat_d   = dst_dat_q;
        dst_last_d  = dst_last_q;
        dst_user_d  = dst_user_q;
        hold_dat_d  = hold_dat_q;
        hold_last_d = hold_last_q;
        hold_user_d = hold_user_q;
        case (state_q)
            ST_EMPTY: begin
                if (src_hs) begin
                    dst_vld_d   = 1'b1;
                    dst_dat_d   = beat_a;
                    dst_last_d  = 1'b0;
                    dst_user_d  = src.t_user;
                    hold_dat_d  = beat_b;
                    hold_last_d = src.t_last;
                    hold_user_d = src.t_user;
                    state_d     = ST_SECOND;
                end else if (dst_hs) begin
                    dst_vld_d = 1'b0;
                end
            end
            default: begin
                if (dst_hs) begin
                    dst_dat_d  = hold_dat_q;
                    dst_last_d = hold_last_q;
                    dst_user_d = hold_user_q;
                    state_d    = ST_EMPTY;
                end
            end
        endcase
    end

    // State and output registers; reset drops any pending beats.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_EMPTY;
            dst_vld_q   <= 1'b0;
            dst_dat_q   <= '0;
            dst_last_q  <= 1'b0;
            dst_user_q  <= '0;
            hold_dat_q  <= '0;
            hold_last_q <= 1'b0;
            hold_user_q <= '0;
        end else begin
            state_q     <= state_d;
            dst_vld_q   <= dst_vld_d;
            dst_dat_q   <= dst_dat_d;
            dst_last_q  <= dst_last_d;
            dst_user_q  <= dst_user_d;
            hold_dat_q  <= hold_dat_d;
            hold_last_q <= hold_last_d;
            hold_user_q <= hold_user_d;
        end
    end

    // Masked input bytes are not expected upstream; flag them but process the beat anyway.
    always_ff @(posedge aclk) begin
        if (aresetn && src_hs) begin
            assert (src.t_keep == '1 && src.t_strb == '1)
                else $error("yuv422_to_444: src t_keep/t_strb not all-ones");
        end
    end

endmodule
